// File: rtl/axil_ic_pkg.sv
// Shared types and helpers for the AXI-Lite priority interconnect arbiters.
// Pure declarations: no timing, no flow control.
package axil_ic_pkg;

   localparam int NUMBER_MASTER_DEF = 4;
   localparam int OH_MAX_W          = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } axil_wr_arb_state_t;

   function automatic logic [7:0] onehot2bin(input logic [OH_MAX_W-1:0] oh);
      logic [7:0] bin;
      bin = '0;
      for (int i = 0; i < OH_MAX_W; i++) begin
         if (oh[i]) bin = bin | 8'(i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/axil_arbiter_wr_if.sv
// Request, slave-handshake and grant signals of the write-channel arbiter.
// The slave modport is the arbiter; the master modport is the request/crossbar side.
interface axil_arbiter_wr_if #(
   parameter int NUMBER_MASTER = 4
);
   localparam int IDX_W = $clog2(NUMBER_MASTER);

   logic [NUMBER_MASTER-1:0] m_axil_awvalid;
   logic [NUMBER_MASTER-1:0] m_axil_wvalid;
   logic                     s_axil_awvalid;
   logic                     s_axil_awready;
   logic                     s_axil_wvalid;
   logic                     s_axil_wready;
   logic                     s_axil_bvalid;
   logic                     s_axil_bready;
   logic [NUMBER_MASTER-1:0] grant_wr;
   logic [IDX_W-1:0]         grant_idx;
   logic                     busy_wr;

   modport slave (
      input  m_axil_awvalid, m_axil_wvalid,
      input  s_axil_awvalid, s_axil_awready,
      input  s_axil_wvalid,  s_axil_wready,
      input  s_axil_bvalid,  s_axil_bready,
      output grant_wr, grant_idx, busy_wr
   );

   modport master (
      output m_axil_awvalid, m_axil_wvalid,
      output s_axil_awvalid, s_axil_awready,
      output s_axil_wvalid,  s_axil_wready,
      output s_axil_bvalid,  s_axil_bready,
      input  grant_wr, grant_idx, busy_wr
   );

endinterface

// File: rtl/axil_prio_enc.sv
// Combinational lowest-index-first priority encoder (one-hot, binary index, valid).
// Zero latency; no flow control of its own.
module axil_prio_enc
   import axil_ic_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = req & (~req + N'(1));
   assign idx    = IDX_W'(onehot2bin(OH_MAX_W'(onehot)));
   assign vld    = |req;

endmodule

// File: rtl/axil_arbiter_wr.sv
// Fixed-priority write arbiter: grant appears 1 cycle after request and is held
// through AW, W and B; re-arbitration only after at least one IDLE cycle.
module axil_arbiter_wr
   import axil_ic_pkg::*;
#(
   parameter int NUMBER_MASTER = NUMBER_MASTER_DEF
) (
   input  logic              aclk,
   input  logic              aresetn,
   axil_arbiter_wr_if.slave  bus
);

   localparam int IDX_W = $clog2(NUMBER_MASTER);

   logic [NUMBER_MASTER-1:0] req;
   logic [NUMBER_MASTER-1:0] enc_onehot;
   logic [IDX_W-1:0]         enc_idx;
   logic                     enc_vld;

   logic aw_hs, w_hs, b_hs;

   axil_wr_arb_state_t       state_q, state_d;
   logic [NUMBER_MASTER-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     busy_q, busy_d;
   logic                     aw_done_q, aw_done_d;
   logic                     w_done_q, w_done_d;

   assign req   = bus.m_axil_awvalid | bus.m_axil_wvalid;
   assign aw_hs = bus.s_axil_awvalid & bus.s_axil_awready;
   assign w_hs  = bus.s_axil_wvalid  & bus.s_axil_wready;
   assign b_hs  = bus.s_axil_bvalid  & bus.s_axil_bready;

   axil_prio_enc #(
      .N     (NUMBER_MASTER),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req    (req),
      .onehot (enc_onehot),
      .idx    (enc_idx),
      .vld    (enc_vld)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (enc_vld) begin
               state_d   = XFER;
               grant_d   = enc_onehot;
               idx_d     = enc_idx;
               busy_d    = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         XFER: begin
            // A handshake in this cycle counts toward leaving XFER right away.
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q  | w_hs;
            if (aw_done_d && w_done_d) state_d = RESP;
         end
         RESP: begin
            if (b_hs) begin
               state_d   = IDLE;
               grant_d   = '0;
               idx_d     = '0;
               busy_d    = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign bus.grant_wr  = grant_q;
   assign bus.grant_idx = idx_q;
   assign bus.busy_wr   = busy_q;

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Bench for axil_arbiter_wr: directed scenarios plus a random run against a
// transaction-level model; inputs change on the falling edge, outputs are sampled there.
module tb_axil_arbiter_wr;
   import axil_ic_pkg::*;

   localparam int N     = 4;
   localparam int IDX_W = $clog2(N);

   logic aclk = 1'b0;
   logic aresetn;
   int   checks = 0;
   int   errors = 0;

   axil_arbiter_wr_if #(.NUMBER_MASTER(N)) bus ();

   axil_arbiter_wr #(.NUMBER_MASTER(N)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus.slave)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Invariants checked on every sampled cycle out of reset.
   logic [N-1:0] prev_grant;
   logic         prev_busy;
   always @(negedge aclk) begin
      if (aresetn) begin
         checks++;
         if (!$onehot0(bus.grant_wr)) begin
            errors++;
            $display("FAIL inv_onehot0 got=%b", bus.grant_wr);
         end
         checks++;
         if (8'(bus.grant_idx) !== onehot2bin(32'(bus.grant_wr))) begin
            errors++;
            $display("FAIL inv_idx got=%0d exp=%0d", bus.grant_idx, onehot2bin(32'(bus.grant_wr)));
         end
         if (prev_busy === 1'b1 && bus.busy_wr === 1'b1) begin
            checks++;
            if (bus.grant_wr !== prev_grant) begin
               errors++;
               $display("FAIL inv_stable got=%b exp=%b", bus.grant_wr, prev_grant);
            end
         end
      end
      prev_grant <= bus.grant_wr;
      prev_busy  <= bus.busy_wr;
   end

   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic clear_hs();
      bus.s_axil_awvalid = 1'b0; bus.s_axil_awready = 1'b0;
      bus.s_axil_wvalid  = 1'b0; bus.s_axil_wready  = 1'b0;
      bus.s_axil_bvalid  = 1'b0; bus.s_axil_bready  = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.m_axil_awvalid = '0;
      bus.m_axil_wvalid  = '0;
      clear_hs();
   endtask

   task automatic set_aw();
      bus.s_axil_awvalid = 1'b1; bus.s_axil_awready = 1'b1;
   endtask

   task automatic set_w();
      bus.s_axil_wvalid = 1'b1; bus.s_axil_wready = 1'b1;
   endtask

   task automatic set_b();
      bus.s_axil_bvalid = 1'b1; bus.s_axil_bready = 1'b1;
   endtask

   // Completes whatever transaction is granted and leaves the arbiter idle.
   task automatic finish_txn();
      bus.m_axil_awvalid = '0; bus.m_axil_wvalid = '0;
      set_aw(); set_w(); tick(); clear_hs();
      set_b(); tick(); clear_hs();
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      idle_inputs();
      bus.m_axil_awvalid = 4'b0001;
      tick(); tick();
      checks++; if (bus.grant_wr !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", bus.grant_wr, 4'b0000); end
      checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.grant_idx); end
      checks++; if (bus.busy_wr !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_wr); end
      bus.m_axil_awvalid = '0;
      aresetn = 1'b1;
      tick();
      checks++; if (bus.busy_wr !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", bus.busy_wr); end
   endtask

   task automatic test_idle_pulses();
      set_aw(); set_w(); set_b();
      tick();
      clear_hs();
      checks++; if (bus.busy_wr !== 1'b0) begin errors++; $display("FAIL idle_pulse_busy got=%b exp=0", bus.busy_wr); end
      bus.m_axil_wvalid = 4'b0001;
      tick();
      checks++; if (bus.grant_wr !== 4'b0001) begin errors++; $display("FAIL w_lead_grant got=%b exp=%b", bus.grant_wr, 4'b0001); end
      set_w(); tick(); clear_hs();
      set_b(); tick(); clear_hs();
      checks++; if (bus.grant_wr !== 4'b0001) begin errors++; $display("FAIL idle_pulse_leak got=%b exp=%b", bus.grant_wr, 4'b0001); end
      finish_txn();
      checks++; if (bus.busy_wr !== 1'b0) begin errors++; $display("FAIL idle_pulse_end got=%b exp=0", bus.busy_wr); end
   endtask

   task automatic test_single();
      logic [N-1:0] exp_g;
      logic [IDX_W-1:0] exp_i;
      bus.m_axil_awvalid = 4'b0100;
      bus.m_axil_wvalid  = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         tick();
         exp_g = (c <= 5) ? 4'b0100 : 4'b0000;
         exp_i = (c <= 5) ? 2'd2 : 2'd0;
         checks++; if (bus.grant_wr !== exp_g) begin errors++; $display("FAIL single_grant c%0d got=%b exp=%b", c, bus.grant_wr, exp_g); end
         checks++; if (bus.grant_idx !== exp_i) begin errors++; $display("FAIL single_idx c%0d got=%0d exp=%0d", c, bus.grant_idx, exp_i); end
         clear_hs();
         if (c == 3) begin set_aw(); set_w(); end
         if (c == 4) begin bus.m_axil_awvalid = '0; bus.m_axil_wvalid = '0; end
         if (c == 5) set_b();
      end
      clear_hs();
   endtask

   task automatic test_back_to_back();
      bus.m_axil_awvalid = 4'b1010;
      tick();
      checks++; if (bus.grant_wr !== 4'b0010) begin errors++; $display("FAIL b2b_first got=%b exp=%b", bus.grant_wr, 4'b0010); end
      set_aw(); set_w(); tick(); clear_hs();
      bus.m_axil_awvalid = 4'b1000;
      set_b(); tick(); clear_hs();
      checks++; if (bus.grant_wr !== 4'b0000) begin errors++; $display("FAIL b2b_gap got=%b exp=%b", bus.grant_wr, 4'b0000); end
      tick();
      checks++; if (bus.grant_wr !== 4'b1000) begin errors++; $display("FAIL b2b_second got=%b exp=%b", bus.grant_wr, 4'b1000); end
      checks++; if (bus.grant_idx !== 2'd3) begin errors++; $display("FAIL b2b_second_idx got=%0d exp=3", bus.grant_idx); end
      finish_txn();
      tick();
   endtask

   task automatic test_no_preempt();
      bus.m_axil_awvalid = 4'b1000;
      tick();
      checks++; if (bus.grant_wr !== 4'b1000) begin errors++; $display("FAIL np_grant got=%b exp=%b", bus.grant_wr, 4'b1000); end
      bus.m_axil_awvalid = 4'b1001;
      tick();
      checks++; if (bus.grant_wr !== 4'b1000) begin errors++; $display("FAIL np_hold_xfer got=%b exp=%b", bus.grant_wr, 4'b1000); end
      set_aw(); set_w(); tick(); clear_hs();
      checks++; if (bus.grant_wr !== 4'b1000) begin errors++; $display("FAIL np_hold_resp got=%b exp=%b", bus.grant_wr, 4'b1000); end
      bus.m_axil_awvalid = 4'b0001;
      set_b(); tick(); clear_hs();
      checks++; if (bus.grant_wr !== 4'b0000) begin errors++; $display("FAIL np_release got=%b exp=%b", bus.grant_wr, 4'b0000); end
      tick();
      checks++; if (bus.grant_wr !== 4'b0001) begin errors++; $display("FAIL np_next got=%b exp=%b", bus.grant_wr, 4'b0001); end
      finish_txn();
      tick();
   endtask

   // mode 0: W two cycles before AW; mode 1: AW two cycles before W; mode 2: same cycle.
   task automatic test_split_case(input int mode);
      logic [N-1:0] oh;
      oh = N'(1) << (mode + 1);
      bus.m_axil_awvalid = oh;
      bus.m_axil_wvalid  = oh;
      tick();
      checks++; if (bus.grant_wr !== oh) begin errors++; $display("FAIL split%0d_grant got=%b exp=%b", mode, bus.grant_wr, oh); end
      if (mode == 0) set_w();
      else if (mode == 1) set_aw();
      else begin set_aw(); set_w(); end
      tick(); clear_hs();
      if (mode != 2) begin
         set_b(); tick(); clear_hs();
         checks++; if (bus.grant_wr !== oh) begin errors++; $display("FAIL split%0d_early_b got=%b exp=%b", mode, bus.grant_wr, oh); end
         if (mode == 0) set_aw(); else set_w();
         tick(); clear_hs();
      end
      checks++; if (bus.grant_wr !== oh) begin errors++; $display("FAIL split%0d_resp got=%b exp=%b", mode, bus.grant_wr, oh); end
      bus.m_axil_awvalid = '0;
      bus.m_axil_wvalid  = '0;
      set_b(); tick(); clear_hs();
      checks++; if (bus.busy_wr !== 1'b0 || bus.grant_wr !== '0) begin errors++; $display("FAIL split%0d_done got busy=%b grant=%b exp busy=0 grant=0000", mode, bus.busy_wr, bus.grant_wr); end
   endtask

   task automatic test_split();
      for (int m = 0; m < 3; m++) test_split_case(m);
   endtask

   task automatic test_reset_mid();
      bus.m_axil_awvalid = 4'b0100;
      tick();
      set_aw(); set_w(); tick(); clear_hs();
      checks++; if (bus.busy_wr !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy_wr); end
      #2 aresetn = 1'b0;
      #1;
      checks++; if (bus.grant_wr !== 4'b0000) begin errors++; $display("FAIL rstmid_grant got=%b exp=%b", bus.grant_wr, 4'b0000); end
      checks++; if (bus.busy_wr !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_wr); end
      bus.m_axil_awvalid = '0;
      @(negedge aclk);
      bus.m_axil_awvalid = 4'b0001;
      aresetn = 1'b1;
      tick();
      checks++; if (bus.grant_wr !== 4'b0001) begin errors++; $display("FAIL rstmid_after got=%b exp=%b", bus.grant_wr, 4'b0001); end
      finish_txn();
      tick();
   endtask

   task automatic test_random();
      int owner;
      bit got_aw, got_w;
      logic [N-1:0] req, exp_g;
      logic [IDX_W-1:0] exp_i;
      logic aw_hs, w_hs, b_hs;
      aresetn = 1'b0; idle_inputs(); tick();
      aresetn = 1'b1; tick();
      owner = -1; got_aw = 1'b0; got_w = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         bus.m_axil_awvalid = N'($urandom_range(0, 15) & $urandom_range(0, 15));
         bus.m_axil_wvalid  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
         bus.s_axil_awvalid = 1'($urandom_range(0, 1)); bus.s_axil_awready = 1'($urandom_range(0, 1));
         bus.s_axil_wvalid  = 1'($urandom_range(0, 1)); bus.s_axil_wready  = 1'($urandom_range(0, 1));
         bus.s_axil_bvalid  = 1'($urandom_range(0, 1)); bus.s_axil_bready  = 1'($urandom_range(0, 1));
         req   = bus.m_axil_awvalid | bus.m_axil_wvalid;
         aw_hs = bus.s_axil_awvalid & bus.s_axil_awready;
         w_hs  = bus.s_axil_wvalid & bus.s_axil_wready;
         b_hs  = bus.s_axil_bvalid & bus.s_axil_bready;
         // Transaction-level model: pick lowest requester, wait for AW and W, then B.
         if (owner < 0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) owner = i;
            got_aw = 1'b0; got_w = 1'b0;
         end else if (!(got_aw && got_w)) begin
            got_aw = got_aw | aw_hs;
            got_w  = got_w | w_hs;
         end else if (b_hs) begin
            owner = -1;
         end
         tick();
         exp_g = (owner < 0) ? '0 : (N'(1) << owner);
         exp_i = (owner < 0) ? '0 : IDX_W'(owner);
         checks++; if (bus.grant_wr !== exp_g) begin errors++; $display("FAIL rand_grant n%0d got=%b exp=%b", n, bus.grant_wr, exp_g); end
         checks++; if (bus.grant_idx !== exp_i) begin errors++; $display("FAIL rand_idx n%0d got=%0d exp=%0d", n, bus.grant_idx, exp_i); end
         checks++; if (bus.busy_wr !== (owner >= 0)) begin errors++; $display("FAIL rand_busy n%0d got=%b exp=%b", n, bus.busy_wr, owner >= 0); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_idle_pulses();
      test_single();
      test_back_to_back();
      test_no_preempt();
      test_split();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
